gomoku_game_ctrl: RTL and testbench

//   Game-flow sequencer for the 8x8 two-player gomoku board.
//   - Clears board memory on power-up and on reset.
//   - Collects x/y keypad entries and validates each move against board memory, then commits it.
//   - Starts the win checker and alternates turns between red and green.
//   - Runs the per-move countdown and drives the flicker/countdown clock-reset strobes and buzzer requests.

---
 rtl/gomoku_game_ctrl_if.sv | 20 ++
 rtl/gomoku_game_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_gomoku_game_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gomoku_game_ctrl_if.sv
// Board-memory and win-checker bus between the game sequencer and its peripherals.
interface gomoku_game_ctrl_if;
    logic [5:0] mem_addr;
    logic       mem_wr_en;
    logic [1:0] mem_wr_data;
    logic [1:0] mem_rd_data;
    logic       chk_start;
    logic       chk_done;
    logic       chk_win;

    modport master (
        output mem_addr, mem_wr_en, mem_wr_data, chk_start,
        input  mem_rd_data, chk_done, chk_win
    );

    modport slave (
        input  mem_addr, mem_wr_en, mem_wr_data, chk_start,
        output mem_rd_data, chk_done, chk_win
    );
endinterface

// File: rtl/gomoku_game_ctrl.sv
// Game-flow sequencer for the 8x8 gomoku board: clear sweep, move entry/validation,
// commit, win check, turn alternation and per-move countdown.
//
// state  | meaning
// OFF    | power switch off, nothing runs
// CLR    | writing 00 to every board cell, one per clk
// INPUT  | collecting x/y keys, countdown running
// RD     | board address of the cursor presented
// CHK    | read data sampled: occupied -> reject, empty -> commit
// WR     | move written, win checker started
// WINCHK | waiting for the win checker
// SWITCH | hand the turn to the other player
// OVER   | game finished, only reset/power-off leave
module gomoku_game_ctrl #(
    parameter int unsigned TIMEOUT_S = 15,
    parameter int unsigned CELLS     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw_power,
    input  logic       i_btn_reset_p,
    input  logic       i_btn_ok_p,
    input  logic       i_key_valid_p,
    input  logic [3:0] i_key_code,
    input  logic       i_countdown_tick,
    gomoku_game_ctrl_if.master bus,
    output logic       o_memrst_done,
    output logic       o_cur_player,
    output logic [2:0] o_cursor_x,
    output logic [2:0] o_cursor_y,
    output logic       o_cursor_vx,
    output logic       o_cursor_vy,
    output logic [3:0] o_countdown,
    output logic       o_game_over,
    output logic [1:0] o_winner,
    output logic       o_flicker_rst_p,
    output logic       o_countdown_rst_p,
    output logic       o_buzz_ok_p,
    output logic       o_buzz_err_p,
    output logic       o_buzz_win_p
);
    localparam logic [5:0] LAST_ADDR = 6'(CELLS - 1);
    localparam logic [6:0] ALL_MOVES = 7'(CELLS);
    localparam logic [3:0] TMO       = 4'(TIMEOUT_S);

    typedef enum logic [3:0] {
        S_OFF, S_CLR, S_INPUT, S_RD, S_CHK, S_WR, S_WINCHK, S_SWITCH, S_OVER
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [5:0] r_addr, w_addr_nxt;
    logic       r_wr_en, w_wr_en_nxt;
    logic [1:0] r_wr_data, w_wr_data_nxt;
    logic       r_chk_start, w_chk_start_nxt;
    logic       r_memrst_done, w_memrst_done_nxt;
    logic       r_player, w_player_nxt;
    logic [2:0] r_cx, w_cx_nxt, r_cy, w_cy_nxt;
    logic       r_vx, w_vx_nxt, r_vy, w_vy_nxt;
    logic [3:0] r_countdown, w_countdown_nxt;
    logic       r_game_over, w_game_over_nxt;
    logic [1:0] r_winner, w_winner_nxt;
    logic [6:0] r_moves, w_moves_nxt;
    logic       r_flicker_p, w_flicker_p_nxt;
    logic       r_cdrst_p, w_cdrst_p_nxt;
    logic       r_ok_p, w_ok_p_nxt;
    logic       r_err_p, w_err_p_nxt;
    logic       r_win_p, w_win_p_nxt;
    logic       w_start_clr;

    // Reset in OFF/CLR is ignored; OFF always proceeds to a fresh sweep once powered.
    assign w_start_clr = (r_state == S_OFF) ||
                         (i_btn_reset_p && (r_state != S_CLR));

    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_wr_en_nxt       = 1'b0;
        w_wr_data_nxt     = r_wr_data;
        w_chk_start_nxt   = 1'b0;
        w_memrst_done_nxt = r_memrst_done;
        w_player_nxt      = r_player;
        w_cx_nxt          = r_cx;
        w_cy_nxt          = r_cy;
        w_vx_nxt          = r_vx;
        w_vy_nxt          = r_vy;
        w_countdown_nxt   = r_countdown;
        w_game_over_nxt   = r_game_over;
        w_winner_nxt      = r_winner;
        w_moves_nxt       = r_moves;
        w_flicker_p_nxt   = 1'b0;
        w_cdrst_p_nxt     = 1'b0;
        w_ok_p_nxt        = 1'b0;
        w_err_p_nxt       = 1'b0;
        w_win_p_nxt       = 1'b0;

        if (!i_sw_power) begin
            w_state_nxt       = S_OFF;
            w_memrst_done_nxt = 1'b0;
        end else if (w_start_clr) begin
            w_state_nxt       = S_CLR;
            w_addr_nxt        = 6'd0;
            w_wr_en_nxt       = 1'b1;
            w_wr_data_nxt     = 2'b00;
            w_memrst_done_nxt = 1'b0;
            w_game_over_nxt   = 1'b0;
            w_winner_nxt      = 2'b00;
        end else begin
            unique case (r_state)
                S_CLR: begin
                    if (r_addr == LAST_ADDR) begin
                        w_state_nxt       = S_INPUT;
                        w_memrst_done_nxt = 1'b1;
                        w_player_nxt      = 1'b0;
                        w_moves_nxt       = 7'd0;
                        w_countdown_nxt   = TMO;
                        w_vx_nxt          = 1'b0;
                        w_vy_nxt          = 1'b0;
                        w_cdrst_p_nxt     = 1'b1;
                        w_flicker_p_nxt   = 1'b1;
                    end else begin
                        w_addr_nxt    = r_addr + 6'd1;
                        w_wr_en_nxt   = 1'b1;
                        w_wr_data_nxt = 2'b00;
                    end
                end
                S_INPUT: begin
                    if (i_btn_ok_p) begin
                        if (r_vx && r_vy) begin
                            w_state_nxt = S_RD;
                            w_addr_nxt  = {r_cy, r_cx};
                        end else begin
                            w_err_p_nxt = 1'b1;
                        end
                    end else if (i_countdown_tick) begin
                        if (r_countdown <= 4'd1) begin
                            w_err_p_nxt = 1'b1;
                            w_state_nxt = S_SWITCH;
                        end else begin
                            w_countdown_nxt = r_countdown - 4'd1;
                        end
                    end else if (i_key_valid_p) begin
                        if (i_key_code[3]) begin
                            w_cx_nxt = i_key_code[2:0];
                            w_vx_nxt = 1'b1;
                        end else begin
                            w_cy_nxt = i_key_code[2:0];
                            w_vy_nxt = 1'b1;
                        end
                    end
                end
                S_RD: w_state_nxt = S_CHK;
                S_CHK: begin
                    if (bus.mem_rd_data != 2'b00) begin
                        w_err_p_nxt = 1'b1;
                        w_vx_nxt    = 1'b0;
                        w_vy_nxt    = 1'b0;
                        w_state_nxt = S_INPUT;
                    end else begin
                        // Strobes are registered on entry so they are high for exactly the WR cycle.
                        w_state_nxt     = S_WR;
                        w_wr_en_nxt     = 1'b1;
                        w_wr_data_nxt   = r_player ? 2'b10 : 2'b01;
                        w_chk_start_nxt = 1'b1;
                        w_moves_nxt     = r_moves + 7'd1;
                    end
                end
                S_WR: w_state_nxt = S_WINCHK;
                S_WINCHK: begin
                    if (bus.chk_done) begin
                        if (bus.chk_win) begin
                            w_winner_nxt    = r_player ? 2'b10 : 2'b01;
                            w_game_over_nxt = 1'b1;
                            w_win_p_nxt     = 1'b1;
                            w_flicker_p_nxt = 1'b1;
                            w_state_nxt     = S_OVER;
                        end else if (r_moves == ALL_MOVES) begin
                            w_winner_nxt    = 2'b00;
                            w_game_over_nxt = 1'b1;
                            w_win_p_nxt     = 1'b1;
                            w_state_nxt     = S_OVER;
                        end else begin
                            w_ok_p_nxt  = 1'b1;
                            w_state_nxt = S_SWITCH;
                        end
                    end
                end
                S_SWITCH: begin
                    w_player_nxt    = ~r_player;
                    w_vx_nxt        = 1'b0;
                    w_vy_nxt        = 1'b0;
                    w_countdown_nxt = TMO;
                    w_cdrst_p_nxt   = 1'b1;
                    w_flicker_p_nxt = 1'b1;
                    w_state_nxt     = S_INPUT;
                end
                S_OVER: w_state_nxt = S_OVER;
                default: w_state_nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_OFF;
            r_addr        <= 6'd0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= 2'b00;
            r_chk_start   <= 1'b0;
            r_memrst_done <= 1'b0;
            r_player      <= 1'b0;
            r_cx          <= 3'd0;
            r_cy          <= 3'd0;
            r_vx          <= 1'b0;
            r_vy          <= 1'b0;
            r_countdown   <= TMO;
            r_game_over   <= 1'b0;
            r_winner      <= 2'b00;
            r_moves       <= 7'd0;
            r_flicker_p   <= 1'b0;
            r_cdrst_p     <= 1'b0;
            r_ok_p        <= 1'b0;
            r_err_p       <= 1'b0;
            r_win_p       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_wr_data     <= w_wr_data_nxt;
            r_chk_start   <= w_chk_start_nxt;
            r_memrst_done <= w_memrst_done_nxt;
            r_player      <= w_player_nxt;
            r_cx          <= w_cx_nxt;
            r_cy          <= w_cy_nxt;
            r_vx          <= w_vx_nxt;
            r_vy          <= w_vy_nxt;
            r_countdown   <= w_countdown_nxt;
            r_game_over   <= w_game_over_nxt;
            r_winner      <= w_winner_nxt;
            r_moves       <= w_moves_nxt;
            r_flicker_p   <= w_flicker_p_nxt;
            r_cdrst_p     <= w_cdrst_p_nxt;
            r_ok_p        <= w_ok_p_nxt;
            r_err_p       <= w_err_p_nxt;
            r_win_p       <= w_win_p_nxt;
        end
    end

    assign bus.mem_addr      = r_addr;
    assign bus.mem_wr_en     = r_wr_en;
    assign bus.mem_wr_data   = r_wr_data;
    assign bus.chk_start     = r_chk_start;
    assign o_memrst_done     = r_memrst_done;
    assign o_cur_player      = r_player;
    assign o_cursor_x        = r_cx;
    assign o_cursor_y        = r_cy;
    assign o_cursor_vx       = r_vx;
    assign o_cursor_vy       = r_vy;
    assign o_countdown       = r_countdown;
    assign o_game_over       = r_game_over;
    assign o_winner          = r_winner;
    assign o_flicker_rst_p   = r_flicker_p;
    assign o_countdown_rst_p = r_cdrst_p;
    assign o_buzz_ok_p       = r_ok_p;
    assign o_buzz_err_p      = r_err_p;
    assign o_buzz_win_p      = r_win_p;
endmodule

// File: tb/tb_gomoku_game_ctrl.sv
// Bench for gomoku_game_ctrl: game-rule model feeding an event scoreboard, plus
// board memory and win-checker responders.
module tb_gomoku_game_ctrl;
    localparam int T = 4;
    localparam logic [1:0] EV_WR = 2'd0, EV_OK = 2'd1, EV_ERR = 2'd2, EV_WIN = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw_power, btn_reset_p, btn_ok_p, key_valid_p, countdown_tick;
    logic [3:0] key_code;
    logic       memrst_done, cur_player, cursor_vx, cursor_vy, game_over;
    logic       flicker_rst_p, countdown_rst_p, buzz_ok_p, buzz_err_p, buzz_win_p;
    logic [2:0] cursor_x, cursor_y;
    logic [3:0] countdown;
    logic [1:0] winner;

    gomoku_game_ctrl_if bus();

    always #5 clk = ~clk;

    gomoku_game_ctrl #(.TIMEOUT_S(T), .CELLS(64)) dut (
        .clk(clk), .rst_n(rst_n), .i_sw_power(sw_power), .i_btn_reset_p(btn_reset_p),
        .i_btn_ok_p(btn_ok_p), .i_key_valid_p(key_valid_p), .i_key_code(key_code),
        .i_countdown_tick(countdown_tick), .bus(bus.master),
        .o_memrst_done(memrst_done), .o_cur_player(cur_player),
        .o_cursor_x(cursor_x), .o_cursor_y(cursor_y), .o_cursor_vx(cursor_vx),
        .o_cursor_vy(cursor_vy), .o_countdown(countdown), .o_game_over(game_over),
        .o_winner(winner), .o_flicker_rst_p(flicker_rst_p),
        .o_countdown_rst_p(countdown_rst_p), .o_buzz_ok_p(buzz_ok_p),
        .o_buzz_err_p(buzz_err_p), .o_buzz_win_p(buzz_win_p)
    );

    typedef struct packed {
        logic [1:0] kind;
        logic [5:0] addr;
        logic [1:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Environment board memory: read data valid one clk after the address.
    logic [1:0] mem [64];
    always @(posedge clk) begin
        bus.mem_rd_data <= mem[bus.mem_addr];
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    end

    function automatic bit five_at(input logic [1:0] b [64], input int x, input int y);
        int dx, dy, n, cx, cy;
        logic [1:0] c;
        c = b[y*8 + x];
        if (c == 2'b00) return 1'b0;
        for (int d = 0; d < 4; d++) begin
            dx = (d == 1) ? 0 : 1;
            dy = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
            n = 1;
            for (int s = -1; s <= 1; s += 2) begin
                cx = x + s*dx;
                cy = y + s*dy;
                while (cx >= 0 && cx < 8 && cy >= 0 && cy < 8 && b[cy*8 + cx] == c) begin
                    n++;
                    cx += s*dx;
                    cy += s*dy;
                end
            end
            if (n >= 5) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Win-checker responder: judges the board it sees after the move lands.
    initial begin
        int a, d;
        bus.chk_done = 1'b0;
        bus.chk_win  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.chk_start) begin
                a = int'(bus.mem_addr);
                d = int'($urandom_range(1, 4));
                repeat (d) @(posedge clk);
                #1;
                bus.chk_win  = five_at(mem, a % 8, a / 8);
                bus.chk_done = 1'b1;
                @(posedge clk);
                #1;
                bus.chk_done = 1'b0;
                bus.chk_win  = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic see(input logic [1:0] kind, input logic [5:0] addr, input logic [1:0] data);
        ev_t a, e;
        a = '{kind: kind, addr: addr, data: data};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected kind=%0d addr=%0d data=%0d", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (a != e) begin
                errors++;
                $display("FAIL event: got kind=%0d addr=%0d data=%0d, expected kind=%0d addr=%0d data=%0d",
                         a.kind, a.addr, a.data, e.kind, e.addr, e.data);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.mem_wr_en) see(EV_WR, bus.mem_addr, bus.mem_wr_data);
                if (buzz_ok_p)  see(EV_OK, 6'd0, 2'd0);
                if (buzz_err_p) see(EV_ERR, 6'd0, 2'd0);
                if (buzz_win_p) see(EV_WIN, 6'd0, winner);
            end
        end
    end

    // Game reference model.
    logic [1:0] mb [64];
    int m_player = 0, m_moves = 0, m_cd = T, m_over = 0, m_winner = 0;
    int m_cx = 0, m_cy = 0, m_vx = 0, m_vy = 0;

    function automatic ev_t mk(input logic [1:0] k, input int a, input int d);
        mk = '{kind: k, addr: 6'(a), data: 2'(d)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) begin
            mb[i] = 2'b00;
            exp_q.push_back(mk(EV_WR, i, 0));
        end
        m_player = 0; m_moves = 0; m_cd = T; m_over = 0; m_winner = 0;
        m_vx = 0; m_vy = 0;
    endtask

    task automatic next_turn();
        m_player = 1 - m_player;
        m_vx = 0; m_vy = 0;
        m_cd = T;
    endtask

    task automatic wait_ready();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (memrst_done) seen = 1'b1;
        end
        check("clear_done_in_time", int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_player"}, int'(cur_player), m_player);
        check({tag, "_countdown"}, int'(countdown), m_cd);
        check({tag, "_vx"}, int'(cursor_vx), m_vx);
        check({tag, "_vy"}, int'(cursor_vy), m_vy);
        check({tag, "_x"}, int'(cursor_x), m_cx);
        check({tag, "_y"}, int'(cursor_y), m_cy);
        check({tag, "_game_over"}, int'(game_over), m_over);
        check({tag, "_winner"}, int'(winner), m_winner);
    endtask

    // One stimulus cycle; the model applies the priority reset > ok > tick > key.
    task automatic act(input bit rst, input bit ok, input bit tick, input bit key, input logic [3:0] code);
        int a, p;
        if (rst) begin
            model_clear();
        end else if (m_over == 0) begin
            if (ok) begin
                if (m_vx == 0 || m_vy == 0) begin
                    exp_q.push_back(mk(EV_ERR, 0, 0));
                end else begin
                    a = m_cy*8 + m_cx;
                    if (mb[a] != 2'b00) begin
                        exp_q.push_back(mk(EV_ERR, 0, 0));
                        m_vx = 0; m_vy = 0;
                    end else begin
                        p = m_player + 1;
                        mb[a] = 2'(p);
                        exp_q.push_back(mk(EV_WR, a, p));
                        m_moves++;
                        if (five_at(mb, m_cx, m_cy)) begin
                            m_over = 1; m_winner = p;
                            exp_q.push_back(mk(EV_WIN, 0, p));
                        end else if (m_moves == 64) begin
                            m_over = 1; m_winner = 0;
                            exp_q.push_back(mk(EV_WIN, 0, 0));
                        end else begin
                            exp_q.push_back(mk(EV_OK, 0, 0));
                            next_turn();
                        end
                    end
                end
            end else if (tick) begin
                if (m_cd == 1) begin
                    exp_q.push_back(mk(EV_ERR, 0, 0));
                    next_turn();
                end else begin
                    m_cd--;
                end
            end else if (key) begin
                if (code >= 4'd8) begin m_cx = int'(code) - 8; m_vx = 1; end
                else begin m_cy = int'(code); m_vy = 1; end
            end
        end
        btn_reset_p = rst; btn_ok_p = ok; countdown_tick = tick;
        key_valid_p = key; key_code = code;
        @(posedge clk);
        #1;
        btn_reset_p = 0; btn_ok_p = 0; countdown_tick = 0; key_valid_p = 0;
        if (rst) wait_ready();
        else repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic move(input int x, input int y);
        act(0, 0, 0, 1, 4'(8 + x));
        act(0, 0, 0, 1, 4'(y));
        act(0, 1, 0, 0, 4'd0);
    endtask

    initial begin
        bit hit;
        sw_power = 0; btn_reset_p = 0; btn_ok_p = 0; key_valid_p = 0;
        countdown_tick = 0; key_code = 0;
        for (int i = 0; i < 64; i++) mb[i] = 2'b00;
        #23;
        check("reset_countdown", int'(countdown), T);
        check("reset_memrst_done", int'(memrst_done), 0);
        check("reset_wr_en", int'(bus.mem_wr_en), 0);
        check("reset_game_over", int'(game_over), 0);
        check("reset_buzz", int'({buzz_ok_p, buzz_err_p, buzz_win_p, flicker_rst_p, countdown_rst_p}), 0);
        rst_n = 1;
        @(posedge clk);
        #1;
        model_clear();
        sw_power = 1;
        wait_ready();
        check_state("powerup");

        // Red at (7,2) accepted, then green on the same cell rejected.
        move(7, 2);
        check_state("red_move");
        move(7, 2);
        check_state("occupied");

        // Green runs out of time.
        repeat (T) act(0, 0, 1, 0, 4'd0);
        check_state("timeout");

        // Red completes x=7, y=2..6.
        move(7, 3); move(0, 0);
        move(7, 4); move(0, 1);
        move(7, 5); move(0, 2);
        move(7, 6);
        check_state("win");
        act(0, 1, 0, 0, 4'd0);
        act(0, 0, 1, 1, 4'd9);
        check_state("over_ignores");

        // Priority of simultaneous events.
        act(1, 1, 0, 0, 4'd0);
        act(0, 1, 1, 1, 4'd12);
        check_state("prio_ok");
        act(0, 0, 1, 1, 4'd3);
        check_state("prio_tick");

        // Reset while the read is in flight: only the clear sweep follows.
        act(0, 0, 0, 1, 4'd10);
        act(0, 0, 0, 1, 4'd5);
        model_clear();
        btn_ok_p = 1;
        @(posedge clk); #1;
        btn_ok_p = 0; btn_reset_p = 1;
        @(posedge clk); #1;
        btn_reset_p = 0;
        wait_ready();
        check_state("reset_mid_rd");

        // Power loss in the middle of a clear sweep.
        for (int i = 0; i <= 20; i++) exp_q.push_back(mk(EV_WR, i, 0));
        btn_reset_p = 1;
        @(posedge clk); #1;
        btn_reset_p = 0;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (bus.mem_wr_en && bus.mem_addr == 6'd20) hit = 1'b1;
        end
        check("sweep_reached_20", int'(hit), 1);
        sw_power = 0;
        repeat (5) @(posedge clk);
        #1;
        check("poweroff_memrst_done", int'(memrst_done), 0);
        check("poweroff_queue_drained", exp_q.size(), 0);
        model_clear();
        sw_power = 1;
        wait_ready();
        check_state("repower");

        // Randomized play.
        for (int n = 0; n < 160; n++) begin
            bit r, o, t, k;
            r = (m_over != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
            o = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 6) == 0);
            k = ($urandom_range(0, 5) != 0);
            act(r, o, t, k, 4'($urandom_range(0, 15)));
            check_state("random");
        end

        repeat (10) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
